// File: rtl/instr_encoder_loader.sv
// MIPS instruction encoder feeding an instruction-memory write port, filling words from address 0.
// Optional build macro ENC_NOP_PAD_EN appends a NOP word after finish to reserve the branch delay slot.
module instr_encoder_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              finish_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [3:0]        op_sel_i,
  input  logic [4:0]        rs_i,
  input  logic [4:0]        rt_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        shamt_i,
  input  logic [15:0]       imm_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [31:0]       wr_data_o,
  output logic [ADDR_W:0]   count_o,
  output logic              done_o,
  output logic              full_o,
  output logic              err_op_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_PAD,
    S_FLUSH,
    S_DONE
  } state_t;

  // count_q doubles as the write pointer; its top bit only sets once memory is full.
  localparam logic [ADDR_W:0] LAST_IDX = {1'b0, {ADDR_W{1'b1}}};

  state_t              state_q;
  logic                wr_en_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [31:0]         wr_data_q;
  logic [ADDR_W:0]     count_q;
  logic                done_q;
  logic                full_q;
  logic                err_op_q;

  logic [31:0]         word_d;
  logic                legal_d;
  logic                accept;
  logic                fills;

  always_comb begin
    word_d  = '0;
    legal_d = 1'b1;
    case (op_sel_i)
      4'd0:  word_d = {6'h00, rs_i, rt_i, rd_i, 5'd0, 6'h20};
      4'd1:  word_d = {6'h00, rs_i, rt_i, rd_i, 5'd0, 6'h22};
      4'd2:  word_d = {6'h00, rs_i, rt_i, rd_i, 5'd0, 6'h24};
      4'd3:  word_d = {6'h00, rs_i, rt_i, rd_i, 5'd0, 6'h25};
      4'd4:  word_d = {6'h00, 5'd0, rt_i, rd_i, shamt_i, 6'h00};
      4'd5:  word_d = {6'h00, 5'd0, rt_i, rd_i, shamt_i, 6'h02};
      4'd6:  word_d = {6'h00, rs_i, rt_i, rd_i, 5'd0, 6'h2A};
      4'd7:  word_d = {6'h08, rs_i, rt_i, imm_i};
      4'd8:  word_d = {6'h0C, rs_i, rt_i, imm_i};
      4'd9:  word_d = {6'h0D, rs_i, rt_i, imm_i};
      4'd10: word_d = {6'h23, rs_i, rt_i, imm_i};
      4'd11: word_d = {6'h2B, rs_i, rt_i, imm_i};
      4'd12: word_d = {6'h04, rs_i, rt_i, imm_i};
      4'd13: word_d = {6'h05, rs_i, rt_i, imm_i};
      default: legal_d = 1'b0;
    endcase
  end

  assign in_ready_o = (state_q == S_RUN) && !full_q;
  assign accept     = in_valid_i && in_ready_o;
  assign fills      = accept && legal_d && (count_q == LAST_IDX);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      count_q   <= '0;
      done_q    <= 1'b0;
      full_q    <= 1'b0;
      err_op_q  <= 1'b0;
    end else begin
      wr_en_q  <= 1'b0;
      err_op_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_q <= S_RUN;
            count_q <= '0;
            done_q  <= 1'b0;
            full_q  <= 1'b0;
          end
        end
        S_RUN: begin
          if (accept) begin
            if (legal_d) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= count_q[ADDR_W-1:0];
              wr_data_q <= word_d;
              count_q   <= count_q + 1'b1;
            end else begin
              err_op_q <= 1'b1;
            end
          end
          // Filling the memory wins over finish, which also skips any pad.
          if (fills) begin
            full_q  <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (finish_i) begin
`ifdef ENC_NOP_PAD_EN
            state_q <= S_PAD;
`else
            if (accept && legal_d) begin
              state_q <= S_FLUSH;
            end else begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
`endif
          end
        end
`ifdef ENC_NOP_PAD_EN
        S_PAD: begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= count_q[ADDR_W-1:0];
          wr_data_q <= '0;
          count_q   <= count_q + 1'b1;
          if (count_q == LAST_IDX) full_q <= 1'b1;
          state_q   <= S_FLUSH;
        end
`endif
        S_FLUSH: begin
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign count_o   = count_q;
  assign done_o    = done_q;
  assign full_o    = full_q;
  assign err_op_o  = err_op_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: an ADDR_W=8 instance for encoding and sequencing,
// and an ADDR_W=2 instance sharing the same stimulus for the capacity boundary.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        finish = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  op_sel = '0;
  logic [4:0]  rs = '0, rt = '0, rd = '0, shamt = '0;
  logic [15:0] imm = '0;

  logic        a_ready, a_wr_en, a_done, a_full, a_err;
  logic [7:0]  a_addr;
  logic [31:0] a_data;
  logic [8:0]  a_count;

  logic        b_ready, b_wr_en, b_done, b_full, b_err;
  logic [1:0]  b_addr;
  logic [31:0] b_data;
  logic [2:0]  b_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_W(8)) u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .finish_i(finish),
    .in_valid_i(in_valid), .in_ready_o(a_ready), .op_sel_i(op_sel),
    .rs_i(rs), .rt_i(rt), .rd_i(rd), .shamt_i(shamt), .imm_i(imm),
    .wr_en_o(a_wr_en), .wr_addr_o(a_addr), .wr_data_o(a_data),
    .count_o(a_count), .done_o(a_done), .full_o(a_full), .err_op_o(a_err)
  );

  instr_encoder_loader #(.ADDR_W(2)) u_small (
    .clk_i(clk), .rst_i(rst), .start_i(start), .finish_i(finish),
    .in_valid_i(in_valid), .in_ready_o(b_ready), .op_sel_i(op_sel),
    .rs_i(rs), .rt_i(rt), .rd_i(rd), .shamt_i(shamt), .imm_i(imm),
    .wr_en_o(b_wr_en), .wr_addr_o(b_addr), .wr_data_o(b_data),
    .count_o(b_count), .done_o(b_done), .full_o(b_full), .err_op_o(b_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [3:0] op, input logic [4:0] s, input logic [4:0] t,
                      input logic [4:0] d, input logic [4:0] sh, input logic [15:0] im);
    in_valid = 1'b1;
    op_sel = op; rs = s; rt = t; rd = d; shamt = sh; imm = im;
  endtask

  task automatic chk_write(input string tag, input logic [7:0] addr, input logic [31:0] data,
                           input logic [8:0] cnt);
    chk({tag, "_wr_en"}, 32'(a_wr_en), 32'd1);
    chk({tag, "_addr"},  32'(a_addr), 32'(addr));
    chk({tag, "_data"},  a_data, data);
    chk({tag, "_count"}, 32'(a_count), 32'(cnt));
  endtask

  initial begin
    tick();
    tick();
    chk("rst_wr_en", 32'(a_wr_en), 32'd0);
    chk("rst_addr", 32'(a_addr), 32'd0);
    chk("rst_data", a_data, 32'd0);
    chk("rst_count", 32'(a_count), 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_full", 32'(a_full), 32'd0);
    chk("rst_err", 32'(a_err), 32'd0);
    chk("rst_ready", 32'(a_ready), 32'd0);

    rst = 1'b0;
    tick();
    chk("idle_ready", 32'(a_ready), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("run_ready", 32'(a_ready), 32'd1);

    beat(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0000);        // add
    tick(); chk_write("add", 8'd0, 32'h0022_1820, 9'd1);
    beat(4'd4, 5'd7, 5'd2, 5'd3, 5'd4, 16'h0000);        // sll, rs forced 0
    tick(); chk_write("sll", 8'd1, 32'h0002_1900, 9'd2);
    beat(4'd7, 5'd0, 5'd8, 5'd31, 5'd3, 16'h0005);       // addi, rd/shamt ignored
    tick(); chk_write("addi", 8'd2, 32'h2008_0005, 9'd3);
    beat(4'd10, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0004);       // lw
    tick(); chk_write("lw", 8'd3, 32'h8C22_0004, 9'd4);
    beat(4'd12, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF);       // beq
    tick(); chk_write("beq", 8'd4, 32'h1022_FFFF, 9'd5);

    beat(4'd15, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0000);       // illegal
    tick();
    chk("ill_err", 32'(a_err), 32'd1);
    chk("ill_wr_en", 32'(a_wr_en), 32'd0);
    chk("ill_count", 32'(a_count), 32'd5);
    chk("ill_addr_hold", 32'(a_addr), 32'd4);
    chk("ill_data_hold", a_data, 32'h1022_FFFF);

    beat(4'd1, 5'd4, 5'd5, 5'd6, 5'd9, 16'h0000);        // sub, shamt forced 0
    tick(); chk_write("sub", 8'd5, 32'h0085_3022, 9'd6);
    chk("sub_err_clr", 32'(a_err), 32'd0);
    beat(4'd11, 5'd29, 5'd31, 5'd7, 5'd0, 16'h8000);     // sw
    tick(); chk_write("sw", 8'd6, 32'hAFBF_8000, 9'd7);
    beat(4'd5, 5'd5, 5'd1, 5'd2, 5'd31, 16'h0000);       // srl, rs forced 0
    tick(); chk_write("srl", 8'd7, 32'h0001_17C2, 9'd8);

    in_valid = 1'b0;
    tick();
    chk("gap_wr_en", 32'(a_wr_en), 32'd0);
    chk("gap_addr_hold", 32'(a_addr), 32'd7);

    beat(4'd13, 5'd2, 5'd3, 5'd0, 5'd0, 16'h0010);       // bne with finish
    finish = 1'b1;
    tick();
    in_valid = 1'b0;
    finish = 1'b0;
    chk_write("bne_fin", 8'd8, 32'h1443_0010, 9'd9);
    chk("bne_fin_done", 32'(a_done), 32'd0);
    chk("bne_fin_ready", 32'(a_ready), 32'd0);
    tick();
`ifdef ENC_NOP_PAD_EN
    chk_write("pad1", 8'd9, 32'h0000_0000, 9'd10);
    chk("pad1_done", 32'(a_done), 32'd0);
    tick();
`endif
    chk("fin_done", 32'(a_done), 32'd1);
    chk("fin_wr_en", 32'(a_wr_en), 32'd0);

    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_done", 32'(a_done), 32'd0);
    chk("restart_count", 32'(a_count), 32'd0);
    chk("restart_ready", 32'(a_ready), 32'd1);
    beat(4'd8, 5'd3, 5'd4, 5'd0, 5'd0, 16'h00FF);        // andi
    tick(); chk_write("andi", 8'd0, 32'h3064_00FF, 9'd1);
    beat(4'd9, 5'd0, 5'd1, 5'd0, 5'd0, 16'h1234);        // ori with start (ignored in RUN)
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_write("ori", 8'd1, 32'h3401_1234, 9'd2);

    in_valid = 1'b0;
    finish = 1'b1;
    tick();
    finish = 1'b0;
    chk("fin_nobeat_wr_en", 32'(a_wr_en), 32'd0);
`ifdef ENC_NOP_PAD_EN
    chk("pad2_pending_done", 32'(a_done), 32'd0);
    chk("pad2_ready", 32'(a_ready), 32'd0);
    tick();
    chk_write("pad2", 8'd2, 32'h0000_0000, 9'd3);
    tick();
`endif
    chk("fin_nobeat_done", 32'(a_done), 32'd1);
    chk("fin_nobeat_ready", 32'(a_ready), 32'd0);

    start = 1'b1;
    tick();
    start = 1'b0;
    beat(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0000);
    rst = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("midrst_wr_en", 32'(a_wr_en), 32'd0);
    chk("midrst_count", 32'(a_count), 32'd0);
    chk("midrst_addr", 32'(a_addr), 32'd0);
    chk("midrst_data", a_data, 32'd0);
    chk("midrst_ready", 32'(a_ready), 32'd0);
    chk("midrst_done", 32'(a_done), 32'd0);

    rst = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("small_ready", 32'(b_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      beat(4'd0, 5'd1, 5'd2, 5'(i), 5'd0, 16'h0000);
      tick();
      if (i < 4) begin
        chk("small_wr_en", 32'(b_wr_en), 32'd1);
        chk("small_addr", 32'(b_addr), 32'(i));
        chk("small_data", b_data, 32'h0022_0020 | (32'(i) << 11));
      end else begin
        chk("small_5th_wr_en", 32'(b_wr_en), 32'd0);
      end
    end
    in_valid = 1'b0;
    chk("small_full", 32'(b_full), 32'd1);
    chk("small_done", 32'(b_done), 32'd1);
    chk("small_ready_low", 32'(b_ready), 32'd0);
    chk("small_count", 32'(b_count), 32'd4);
    chk("small_addr_hold", 32'(b_addr), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
